fdma_mem_responder: RTL and testbench
=====================================

# fdma_mem_responder

Memory-backed responder for the FDMA package interface (`pkg_wr_*` / `pkg_rd_*`), sitting where the FDMA/PS DDR subsystem normally sits. It accepts write and read package requests from a user-side initiator (e.g. the `ps_ddr` test engine), pulls or supplies 32-bit words with the same strobe and last semantics the FDMA uses, and stores them in an internal synchronous single-port RAM. This lets initiator logic be simulated or run on-fabric without the PS, AXI or DDR.

## Interface
- `MEM_WORDS`, 4096: RAM depth in 32-bit words; power of two.
- `BURST_LEN`, 256: after every `BURST_LEN` beats within one package, insert exactly one idle cycle. This models an AXI burst boundary. 0 disables gaps.
- `ui_clk` in 1: the only clock.
- `ui_rstn` in 1: reset, synchronous, active-low.
- `pkg_wr_areq` in 1: write package request, one-cycle pulse.
- `pkg_wr_addr` in 32: byte address, sampled with `pkg_wr_areq`.
- `pkg_wr_size` in 32: length in words, sampled with `pkg_wr_areq`.
- `pkg_wr_en` out 1: beat strobe; `pkg_wr_data` is captured at the edge ending this cycle.
- `pkg_wr_data` in 32: write data.
- `pkg_wr_last` out 1: high with the final `pkg_wr_en` of the package.
- `pkg_rd_areq` in 1: read package request, one-cycle pulse.
- `pkg_rd_addr` in 32: byte address.
- `pkg_rd_size` in 32: length in words.
- `pkg_rd_en` out 1: `pkg_rd_data` is valid this cycle.
- `pkg_rd_data` out 32: read data.
- `pkg_rd_last` out 1: high with the final `pkg_rd_en`.

## Operation
- **Word index.** `idx = addr[log2(MEM_WORDS)+1:2]`. `addr[1:0]` is ignored. Upper bits are ignored, so addresses alias modulo the RAM size. The index increments by 1 per beat and wraps from `MEM_WORDS-1` to 0.
- **Request latching.** Each channel has a one-deep pending slot holding valid, addr and size. An `areq` writes the slot.
  - If the slot is already valid, the new request overwrites it. This is a protocol violation by the initiator.
  - An `areq` with size 0 is discarded: no beats, and no slot change.
- **FSM states:** IDLE, WR, RD, GAP, DONE.
  - **IDLE:** if the write slot is valid, go to WR. Otherwise, if the read slot is valid, go to RD. Write wins on a tie. The slot is consumed on the transition: its contents are loaded into the working address and remaining-count registers, and its valid bit is cleared.
  - **WR:** `pkg_wr_en` = 1 each cycle. RAM write `mem[idx] <= pkg_wr_data`. Remaining count decrements.
  - **RD:** RAM read issued at `idx` each cycle. Remaining count decrements.
  - **Leaving WR/RD:** the last beat goes to DONE. Hitting the `BURST_LEN` boundary with beats remaining goes to GAP.
  - **GAP:** one cycle with no strobe, then return to the originating WR or RD.
  - **DONE:** one idle cycle, then IDLE.
- **Concurrency.** A request arriving while the other channel is busy is served after the current package, in its own turn. A request for the channel that is currently busy is latched and served afterwards. It does not merge with the package in progress.
- **Size width.** Size is 32-bit, but the counter is 32-bit too. Sizes larger than `MEM_WORDS` are legal and wrap the RAM.
- **Reset.** All outputs return to 0 and all state is cleared, including pending slots and the gap counter. RAM contents are not reset. A reset mid-package aborts it: no `last` strobe is emitted.

## Timing
- All outputs are registered.
- Reset values: `pkg_wr_en`, `pkg_wr_last`, `pkg_rd_en`, `pkg_rd_last` = 0. `pkg_rd_data` = 0.
- **Write latency:**
  - `areq` at cycle T latches the slot at edge T.
  - The FSM leaves IDLE at edge T+1.
  - The first `pkg_wr_en` is high in cycle T+2.
- **Write throughput:** N beats on consecutive cycles, except for GAP cycles. `pkg_wr_last` coincides with beat N.
- **Read latency:** the first `pkg_rd_en` is high in cycle T+3 (one extra cycle for the RAM read). `pkg_rd_en` and `pkg_rd_last` are the RAM-issue strobes delayed by one cycle, aligned with the data.
- **Read data hold:** `pkg_rd_data` holds its last value while `pkg_rd_en` = 0.
- **Turnaround:** two idle cycles between packages at minimum (DONE, then IDLE). A read after a write observes the written data.

## Structure
- Shared package `fdma_pkg`: FSM state enum, `FDMA_DW` = 32, and a `pkg_req_t` struct (addr, size, valid).
- Sub-module `fdma_spram`: a single-port synchronous RAM (`MEM_WORDS` × 32, one-cycle read, write-first is not required).
- Everything else stays in `fdma_mem_responder`.

## Test plan
- **Basic write then read.** Write addr 0x0000_0100, size 8, data 1..8. Then read the same address, size 8.
  - Expect 8 `pkg_wr_en` beats with last on beat 8.
  - Expect `pkg_rd_data` 1..8 with `pkg_rd_last` on the 8th beat.
  - First `pkg_rd_en` occurs 3 cycles after `pkg_rd_areq`.
- **Burst gaps.** `BURST_LEN`=4, write size 10. Expect beat pattern 4, gap, 4, gap, 2: 12 cycles from first to last strobe.
- **Simultaneous requests.** `pkg_wr_areq` and `pkg_rd_areq` in the same cycle, same addr, size 4.
  - The write completes first.
  - The read returns the newly written data.
  - No `rd_en` overlaps `wr_en`.
- **Wrap-around.** `MEM_WORDS`=16. Write addr 0x38 (idx 14), size 4, data A,B,C,D.
  - Expect A and B at idx 14 and 15, C and D at idx 0 and 1.
  - Reading addr 0x0 with size 2 returns C, D.
- **Zero size and mid-package reset.**
  - Size-0 `areq`: no strobes, FSM stays IDLE.
  - `ui_rstn` low for 1 cycle during beat 3 of a size-8 read: all strobes are 0 from the next cycle, and no `pkg_rd_last` is seen.
  - A subsequent request then behaves normally.
- **Back-to-back same channel.** A second `pkg_wr_areq` issued during the first package, size 3 each. Expect 3 beats with last, then a gap of at least 2 cycles, then 3 beats with last.

Source files
------------

// File: rtl/fdma_pkg.sv
// Shared types for the FDMA package-interface memory responder.
package fdma_pkg;

    localparam int FDMA_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_GAP,
        ST_DONE
    } fdma_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] size;
        logic        valid;
    } pkg_req_t;

endpackage

// File: rtl/fdma_spram.sv
// Single-port synchronous RAM; the read register only updates on a read so it holds between reads.
module fdma_spram
    import fdma_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               we,
    input  logic               re,
    input  logic [AW-1:0]      addr,
    input  logic [FDMA_DW-1:0] wdata,
    output logic [FDMA_DW-1:0] rdata
);

    logic [FDMA_DW-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/fdma_mem_responder.sv
// Memory-backed stand-in for the FDMA/PS DDR path: serves pkg_wr/pkg_rd packages from an on-chip RAM.
module fdma_mem_responder
    import fdma_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int BURST_LEN = 256
) (
    input  logic               ui_clk,
    input  logic               ui_rstn,
    input  logic               pkg_wr_areq,
    input  logic [31:0]        pkg_wr_addr,
    input  logic [31:0]        pkg_wr_size,
    output logic               pkg_wr_en,
    input  logic [FDMA_DW-1:0] pkg_wr_data,
    output logic               pkg_wr_last,
    input  logic               pkg_rd_areq,
    input  logic [31:0]        pkg_rd_addr,
    input  logic [31:0]        pkg_rd_size,
    output logic               pkg_rd_en,
    output logic [FDMA_DW-1:0] pkg_rd_data,
    output logic               pkg_rd_last
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [31:0] BURST_M1 = 32'(BURST_LEN - 1);

    // Handshake: areq is a one-cycle request with no back-pressure; wr_en/rd_en are
    // unconditional beat strobes (no ready), each beat is consumed/valid in the cycle it is high.
    fdma_state_e   state;
    pkg_req_t      wr_slot;
    pkg_req_t      rd_slot;
    logic [AW-1:0] cur_idx;
    logic [31:0]   rem;
    logic [31:0]   beat_cnt;
    logic          gap_wr;
    logic          burst_end;
    logic          unused_addr_bits;

    assign burst_end = (BURST_LEN != 0) && (beat_cnt == BURST_M1);
    assign unused_addr_bits = ^{wr_slot.addr[31:AW+2], wr_slot.addr[1:0],
                                rd_slot.addr[31:AW+2], rd_slot.addr[1:0]};

    always_ff @(posedge ui_clk) begin
        if (!ui_rstn) begin
            state       <= ST_IDLE;
            wr_slot     <= '0;
            rd_slot     <= '0;
            cur_idx     <= '0;
            rem         <= '0;
            beat_cnt    <= '0;
            gap_wr      <= 1'b0;
            pkg_wr_en   <= 1'b0;
            pkg_wr_last <= 1'b0;
            pkg_rd_en   <= 1'b0;
            pkg_rd_last <= 1'b0;
        end else begin
            // Read strobes trail the RAM issue cycle by one so they line up with rdata.
            pkg_rd_en   <= (state == ST_RD);
            pkg_rd_last <= (state == ST_RD) && (rem == 32'd1);
            pkg_wr_en   <= 1'b0;
            pkg_wr_last <= 1'b0;

            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    if (wr_slot.valid) begin
                        state         <= ST_WR;
                        cur_idx       <= wr_slot.addr[AW+1:2];
                        rem           <= wr_slot.size;
                        wr_slot.valid <= 1'b0;
                        pkg_wr_en     <= 1'b1;
                        pkg_wr_last   <= (wr_slot.size == 32'd1);
                    end else if (rd_slot.valid) begin
                        state         <= ST_RD;
                        cur_idx       <= rd_slot.addr[AW+1:2];
                        rem           <= rd_slot.size;
                        rd_slot.valid <= 1'b0;
                    end
                end
                ST_WR, ST_RD: begin
                    cur_idx <= cur_idx + 1'b1;
                    rem     <= rem - 32'd1;
                    if (rem == 32'd1) begin
                        state <= ST_DONE;
                    end else if (burst_end) begin
                        state    <= ST_GAP;
                        gap_wr   <= (state == ST_WR);
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 32'd1;
                        if (state == ST_WR) begin
                            pkg_wr_en   <= 1'b1;
                            pkg_wr_last <= (rem == 32'd2);
                        end
                    end
                end
                ST_GAP: begin
                    state <= gap_wr ? ST_WR : ST_RD;
                    if (gap_wr) begin
                        pkg_wr_en   <= 1'b1;
                        pkg_wr_last <= (rem == 32'd1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Placed after the consume so a request arriving on the consume edge is kept.
            if (pkg_wr_areq && (pkg_wr_size != 32'd0)) begin
                wr_slot <= '{addr: pkg_wr_addr, size: pkg_wr_size, valid: 1'b1};
            end
            if (pkg_rd_areq && (pkg_rd_size != 32'd0)) begin
                rd_slot <= '{addr: pkg_rd_addr, size: pkg_rd_size, valid: 1'b1};
            end
        end
    end

    fdma_spram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk   (ui_clk),
        .rstn  (ui_rstn),
        .we    (state == ST_WR),
        .re    (state == ST_RD),
        .addr  (cur_idx),
        .wdata (pkg_wr_data),
        .rdata (pkg_rd_data)
    );

endmodule

// File: tb/tb_fdma_mem_responder.sv
// Scoreboard bench for fdma_mem_responder: small RAM and short bursts so wrap and gaps show up quickly.
module tb_fdma_mem_responder;

    localparam int MEM_WORDS = 16;
    localparam int BURST_LEN = 4;

    logic        ui_clk = 1'b0;
    logic        ui_rstn = 1'b0;
    logic        pkg_wr_areq = 1'b0;
    logic [31:0] pkg_wr_addr = '0;
    logic [31:0] pkg_wr_size = '0;
    logic        pkg_wr_en;
    logic [31:0] pkg_wr_data = '0;
    logic        pkg_wr_last;
    logic        pkg_rd_areq = 1'b0;
    logic [31:0] pkg_rd_addr = '0;
    logic [31:0] pkg_rd_size = '0;
    logic        pkg_rd_en;
    logic [31:0] pkg_rd_data;
    logic        pkg_rd_last;

    fdma_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .ui_clk      (ui_clk),
        .ui_rstn     (ui_rstn),
        .pkg_wr_areq (pkg_wr_areq),
        .pkg_wr_addr (pkg_wr_addr),
        .pkg_wr_size (pkg_wr_size),
        .pkg_wr_en   (pkg_wr_en),
        .pkg_wr_data (pkg_wr_data),
        .pkg_wr_last (pkg_wr_last),
        .pkg_rd_areq (pkg_rd_areq),
        .pkg_rd_addr (pkg_rd_addr),
        .pkg_rd_size (pkg_rd_size),
        .pkg_rd_en   (pkg_rd_en),
        .pkg_rd_data (pkg_rd_data),
        .pkg_rd_last (pkg_rd_last)
    );

    // ---------------- clock / reset ----------------
    always #5 ui_clk = ~ui_clk;

    int cyc = 0;
    always @(posedge ui_clk) cyc <= cyc + 1;

    // ---------------- reference model and scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    logic [31:0] model_mem [MEM_WORDS];
    logic [31:0] pkt_data[$];
    logic [31:0] wr_data_q[$];
    logic [0:0]  exp_wr_q[$];
    logic [32:0] exp_rd_q[$];
    int          wr_cyc_q[$];
    int          rd_cyc_q[$];
    logic [31:0] hold_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int word_idx(input logic [31:0] addr, input int k);
        logic [31:0] w;
        w = (addr >> 2) + 32'(k);
        return int'(w % 32'(MEM_WORDS));
    endfunction

    task automatic fill_rand(input int n);
        pkt_data.delete();
        for (int k = 0; k < n; k++) pkt_data.push_back($urandom());
    endtask

    task automatic model_wr(input logic [31:0] addr, input int n);
        for (int k = 0; k < n; k++) begin
            model_mem[word_idx(addr, k)] = pkt_data[k];
            wr_data_q.push_back(pkt_data[k]);
            exp_wr_q.push_back(1'(k == n - 1));
        end
    endtask

    task automatic model_rd(input logic [31:0] addr, input int n);
        for (int k = 0; k < n; k++)
            exp_rd_q.push_back({1'(k == n - 1), model_mem[word_idx(addr, k)]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic issue(input bit do_wr, input bit do_rd,
                         input logic [31:0] wa, input logic [31:0] ws,
                         input logic [31:0] ra, input logic [31:0] rs, output int c);
        pkg_wr_areq = do_wr;
        pkg_wr_addr = wa;
        pkg_wr_size = ws;
        pkg_rd_areq = do_rd;
        pkg_rd_addr = ra;
        pkg_rd_size = rs;
        c = cyc;
        tick();
        pkg_wr_areq = 1'b0;
        pkg_rd_areq = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check("done_timeout", 64'(n < 3000), 64'd1);
        repeat (4) tick();
    endtask

    // Beat k of a package lands at issue + latency + k, plus one cycle per completed burst.
    task automatic check_beats(input bit is_rd, input int c, input int lat, input int n);
        int q[$];
        if (is_rd) q = rd_cyc_q; else q = wr_cyc_q;
        check(is_rd ? "rd_beat_count" : "wr_beat_count", 64'(q.size()), 64'(n));
        for (int k = 0; k < n && k < q.size(); k++)
            check(is_rd ? "rd_beat_cycle" : "wr_beat_cycle", 64'(q[k]), 64'(c + lat + k + k / BURST_LEN));
    endtask

    task automatic clear_cyc();
        wr_cyc_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic do_write(input logic [31:0] addr, input int n);
        int c;
        model_wr(addr, n);
        clear_cyc();
        issue(1'b1, 1'b0, addr, 32'(n), '0, '0, c);
        wait_done();
        check_beats(1'b0, c, 2, n);
    endtask

    task automatic do_read(input logic [31:0] addr, input int n);
        int c;
        model_rd(addr, n);
        clear_cyc();
        issue(1'b0, 1'b1, '0, '0, addr, 32'(n), c);
        wait_done();
        check_beats(1'b1, c, 3, n);
    endtask

    // Write data is supplied in the cycle the DUT strobes pkg_wr_en.
    always @(posedge ui_clk) begin
        #1;
        if (pkg_wr_en) begin
            if (wr_data_q.size() != 0) pkg_wr_data = wr_data_q.pop_front();
            else pkg_wr_data = $urandom();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge ui_clk) begin
        if (mon_on) begin
            if (pkg_wr_en || pkg_rd_en)
                check("wr_rd_overlap", 64'(pkg_wr_en & pkg_rd_en), 64'd0);
            if (pkg_wr_en) begin
                wr_cyc_q.push_back(cyc);
                check("wr_beat_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) check("wr_last", 64'(pkg_wr_last), 64'(exp_wr_q.pop_front()));
            end else begin
                check("wr_last_idle", 64'(pkg_wr_last), 64'd0);
            end
            if (pkg_rd_en) begin
                rd_cyc_q.push_back(cyc);
                check("rd_beat_expected", 64'(exp_rd_q.size() != 0), 64'd1);
                if (exp_rd_q.size() != 0) begin
                    logic [32:0] e;
                    e = exp_rd_q.pop_front();
                    check("rd_last_data", 64'({pkg_rd_last, pkg_rd_data}), 64'(e));
                    hold_exp = e[31:0];
                end
            end else begin
                check("rd_last_idle", 64'(pkg_rd_last), 64'd0);
                check("rd_data_hold", 64'(pkg_rd_data), 64'(hold_exp));
            end
            if (!ui_rstn) hold_exp = '0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c, c2;
        logic [31:0] a;
        int n;

        repeat (3) tick();
        ui_rstn = 1'b1;
        tick();
        check("rst_wr_en", 64'(pkg_wr_en), 64'd0);
        check("rst_wr_last", 64'(pkg_wr_last), 64'd0);
        check("rst_rd_en", 64'(pkg_rd_en), 64'd0);
        check("rst_rd_last", 64'(pkg_rd_last), 64'd0);
        check("rst_rd_data", 64'(pkg_rd_data), 64'd0);
        mon_on = 1'b1;

        // Initialise the whole RAM so every later read has a known model value.
        fill_rand(MEM_WORDS);
        do_write(32'h0, MEM_WORDS);

        // Basic write then read.
        pkt_data.delete();
        for (int k = 1; k <= 8; k++) pkt_data.push_back(32'(k));
        do_write(32'h0000_0100, 8);
        do_read(32'h0000_0100, 8);

        // Burst gaps: 4, gap, 4, gap, 2 -> last strobe 11 cycles after the first.
        fill_rand(10);
        do_write(32'h0000_0020, 10);
        if (wr_cyc_q.size() == 10) check("burst_span", 64'(wr_cyc_q[9] - wr_cyc_q[0]), 64'd11);
        do_read(32'h0000_0020, 10);

        // Simultaneous requests: write first, read sees new data.
        fill_rand(4);
        a = 32'h0000_0010;
        model_wr(a, 4);
        model_rd(a, 4);
        clear_cyc();
        issue(1'b1, 1'b1, a, 32'd4, a, 32'd4, c);
        wait_done();
        check_beats(1'b0, c, 2, 4);
        check("simul_rd_count", 64'(rd_cyc_q.size()), 64'd4);
        if (rd_cyc_q.size() != 0) check("simul_rd_first", 64'(rd_cyc_q[0]), 64'(c + 9));

        // Wrap-around: idx 14, 15, 0, 1.
        pkt_data.delete();
        pkt_data.push_back(32'hAAAA_0001);
        pkt_data.push_back(32'hBBBB_0002);
        pkt_data.push_back(32'hCCCC_0003);
        pkt_data.push_back(32'hDDDD_0004);
        do_write(32'h0000_0038, 4);
        do_read(32'h0000_0000, 2);
        do_read(32'h0000_0038, 4);

        // Zero-size requests produce nothing.
        clear_cyc();
        issue(1'b1, 1'b1, 32'h40, 32'd0, 32'h40, 32'd0, c);
        repeat (10) tick();
        check("zero_wr_beats", 64'(wr_cyc_q.size()), 64'd0);
        check("zero_rd_beats", 64'(rd_cyc_q.size()), 64'd0);
        fill_rand(2);
        do_write(32'h0000_0004, 2);

        // Reset during beat 3 of an 8-beat read: three beats seen, no last.
        a = 32'h0000_0008;
        for (int k = 0; k < 3; k++) exp_rd_q.push_back({1'b0, model_mem[word_idx(a, k)]});
        clear_cyc();
        issue(1'b0, 1'b1, '0, '0, a, 32'd8, c);
        repeat (4) tick();
        ui_rstn = 1'b0;
        tick();
        ui_rstn = 1'b1;
        check("abort_rd_en", 64'(pkg_rd_en), 64'd0);
        check("abort_rd_last", 64'(pkg_rd_last), 64'd0);
        check("abort_rd_data", 64'(pkg_rd_data), 64'd0);
        check("abort_wr_en", 64'(pkg_wr_en), 64'd0);
        repeat (12) tick();
        check("abort_rd_beats", 64'(rd_cyc_q.size()), 64'd3);
        check("abort_exp_left", 64'(exp_rd_q.size()), 64'd0);
        fill_rand(5);
        do_write(32'h0000_0008, 5);
        do_read(32'h0000_0008, 5);

        // Back-to-back writes on the same channel.
        fill_rand(3);
        model_wr(32'h0000_0030, 3);
        clear_cyc();
        issue(1'b1, 1'b0, 32'h0000_0030, 32'd3, '0, '0, c);
        tick();
        fill_rand(3);
        model_wr(32'h0000_0000, 3);
        issue(1'b1, 1'b0, 32'h0000_0000, 32'd3, '0, '0, c2);
        wait_done();
        check("b2b_count", 64'(wr_cyc_q.size()), 64'd6);
        if (wr_cyc_q.size() == 6) begin
            check("b2b_first_last", 64'(wr_cyc_q[2]), 64'(c + 4));
            check("b2b_gap", 64'(wr_cyc_q[3] - wr_cyc_q[2] >= 3), 64'd1);
        end
        do_read(32'h0000_0030, 3);
        do_read(32'h0000_0000, 3);

        // Randomised traffic, including sizes that wrap the RAM.
        for (int i = 0; i < 20; i++) begin
            a = $urandom();
            n = $urandom_range(1, 40);
            if ($urandom_range(0, 1) == 1) begin
                fill_rand(n);
                do_write(a, n);
            end else begin
                do_read(a, n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
